// File: rtl/instruction_loader.sv
// instruction_loader
//
// Fills the instruction memory from a length-prefixed, little-endian byte stream while
// holding the core in reset. Stream: N[7:0], N[15:8], then 4*N payload bytes, assembled
// into 32-bit words written at word addresses 0..N-1. Legal lengths are 1..DEPTH; anything
// else faults without writing.
//
// Optional feature (macro LOADER_CHECKSUM_EN): one extra byte follows the payload and must
// equal the XOR of all payload bytes; a mismatch faults after the words are written.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start                one-cycle load request, honoured only when idle
//   byte_valid/byte_data source byte; transfer when byte_valid && byte_ready
//   byte_ready           loader can take a byte this cycle
//   imem_we/addr/wdata   registered instruction memory write port (word addressed)
//   cpu_hold             holds the core in reset during a load and after a fault
//   done                 one-cycle pulse on a successful load
//   error                sticky fault flag, cleared by the next accepted start
//   words_loaded         words written in the current load
module instruction_loader #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
`ifdef LOADER_CHECKSUM_EN
        StChk,
`endif
        StDone,
        StErr
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_len_lo;
    logic [ADDR_W:0]     r_len;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_word;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_hold;
    logic                r_error;
    logic [ADDR_W:0]     r_words;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          r_xor;
    logic                w_last_byte;
`endif

    logic                w_accept;
    logic [15:0]         w_len_full;
    logic                w_len_legal;
    logic [ADDR_W:0]     w_words_inc;
    logic                w_image_written;

    assign w_accept        = byte_valid && byte_ready;
    assign w_len_full      = {byte_data, r_len_lo};
    assign w_len_legal     = (w_len_full != 16'd0) && (32'(w_len_full) <= DEPTH);
    assign w_words_inc     = r_words + {{ADDR_W{1'b0}}, 1'b1};
    // All N words have been committed to the write port (the last one may still be on it).
    assign w_image_written = (r_words == r_len);

`ifdef LOADER_CHECKSUM_EN
    assign w_last_byte = (r_state == StData) && w_accept && (r_byte_cnt == 2'd3) &&
                         (w_words_inc == r_len);
`endif

    // byte_ready drops for one cycle after the final payload byte while the last write
    // is on the port, so DONE follows that write rather than coinciding with it.
    always_comb begin
        byte_ready = 1'b0;
        unique case (r_state)
            StLenLo, StLenHi: byte_ready = 1'b1;
            StData:           byte_ready = !w_image_written;
`ifdef LOADER_CHECKSUM_EN
            StChk:            byte_ready = 1'b1;
`endif
            default:          byte_ready = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) w_state_next = StLenLo;
            end
            StLenLo: begin
                if (w_accept) w_state_next = StLenHi;
            end
            StLenHi: begin
                if (w_accept) w_state_next = w_len_legal ? StData : StErr;
            end
            StData: begin
`ifdef LOADER_CHECKSUM_EN
                if (w_last_byte) w_state_next = StChk;
`else
                if (w_image_written) w_state_next = StDone;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            StChk: begin
                if (w_accept) w_state_next = (byte_data == r_xor) ? StDone : StErr;
            end
`endif
            StDone:  w_state_next = StIdle;
            StErr:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_len_lo   <= 8'd0;
            r_len      <= '0;
            r_byte_cnt <= 2'd0;
            r_word     <= 24'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_hold     <= 1'b0;
            r_error    <= 1'b0;
            r_words    <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_xor      <= 8'd0;
`endif
        end else begin
            r_state <= w_state_next;
            r_we    <= 1'b0;

            if (r_state == StIdle && start) begin
                r_hold     <= 1'b1;
                r_error    <= 1'b0;
                r_words    <= '0;
                r_byte_cnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                r_xor      <= 8'd0;
`endif
            end

            if (r_state == StLenLo && w_accept) r_len_lo <= byte_data;
            // Only meaningful when legal, in which case it fits in ADDR_W+1 bits.
            if (r_state == StLenHi && w_accept) r_len <= w_len_full[ADDR_W:0];

            if (r_state == StData && w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                r_xor      <= r_xor ^ byte_data;
`endif
                case (r_byte_cnt)
                    2'd0: r_word[7:0]   <= byte_data;
                    2'd1: r_word[15:8]  <= byte_data;
                    2'd2: r_word[23:16] <= byte_data;
                    default: begin
                        r_we    <= 1'b1;
                        r_addr  <= r_words[ADDR_W-1:0];
                        r_wdata <= {byte_data, r_word};
                        r_words <= w_words_inc;
                    end
                endcase
            end

            if (w_state_next == StErr && r_state != StErr) r_error <= 1'b1;
            if (w_state_next == StDone) r_hold <= 1'b0;
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign cpu_hold     = r_hold;
    assign done         = (r_state == StDone);
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: load tasks push expected writes and
// completion events; a negedge monitor pops and compares when the DUT presents them.
module tb_instruction_loader;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 10;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    instruction_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];
    typedef struct { int unsigned addr; logic [31:0] data; } wr_t;
    typedef struct { int kind; int n; } ev_t;  // kind 1 = done, 2 = error

    wr_t exp_wr[$];
    ev_t exp_ev[$];
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // ---------------- monitor ----------------
    logic prev_err = 1'b0;
    logic prev_we = 1'b0;
    wr_t  mon_w;
    ev_t  mon_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_err = 1'b0;
            prev_we  = 1'b0;
        end else begin
            if (imem_we) begin
                if (exp_wr.size() == 0) begin
                    fail_now($sformatf("unexpected_write addr=%0d data=0x%08h", imem_addr,
                                       imem_wdata));
                end else begin
                    mon_w = exp_wr.pop_front();
                    chk("write_addr", 64'(imem_addr), 64'(mon_w.addr));
                    chk("write_data", 64'(imem_wdata), 64'(mon_w.data));
                end
            end
            if (done) begin
                if (exp_ev.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    mon_e = exp_ev.pop_front();
                    chk("event_is_done", 64'(mon_e.kind), 64'd1);
                    chk("done_cpu_hold", 64'(cpu_hold), 64'd0);
                    chk("done_words_loaded", 64'(words_loaded), 64'(mon_e.n));
                    chk("done_writes_drained", 64'(exp_wr.size()), 64'd0);
`ifndef LOADER_CHECKSUM_EN
                    chk("done_follows_last_write", 64'(prev_we), 64'd1);
`endif
                end
            end
            if (error && !prev_err) begin
                if (exp_ev.size() == 0) begin
                    fail_now("unexpected_error");
                end else begin
                    mon_e = exp_ev.pop_front();
                    chk("event_is_error", 64'(mon_e.kind), 64'd2);
                    chk("error_cpu_hold", 64'(cpu_hold), 64'd1);
                    chk("error_words_loaded", 64'(words_loaded), 64'(mon_e.n));
                end
            end
            prev_err = error;
            prev_we  = imem_we;
        end
    end

    // ---------------- reference model ----------------
    function automatic bit legal_len(input int n);
        return (n >= 1) && (n <= int'(DEPTH));
    endfunction

    function automatic byte_q_t build_stream(input word_q_t words, input int n,
                                             input bit corrupt);
        byte_q_t     b;
        logic [7:0]  cs = 8'd0;
        logic [7:0]  v;
        logic [15:0] n16 = 16'(n);
        b.push_back(n16[7:0]);
        b.push_back(n16[15:8]);
        if (legal_len(n)) begin
            for (int k = 0; k < n; k++) begin
                for (int j = 0; j < 4; j++) begin
                    v = 8'(words[k] >> (8 * j));
                    b.push_back(v);
                    cs = cs ^ v;
                end
            end
            if (CSUM_EN) b.push_back(corrupt ? (cs ^ 8'h01) : cs);
        end
        return b;
    endfunction

    task automatic push_expect(input word_q_t words, input int n, input bit corrupt);
        wr_t w;
        ev_t e;
        if (legal_len(n)) begin
            for (int k = 0; k < n; k++) begin
                w.addr = k;
                w.data = words[k];
                exp_wr.push_back(w);
            end
            e.kind = (CSUM_EN && corrupt) ? 2 : 1;
            e.n    = n;
        end else begin
            e.kind = 2;
            e.n    = 0;
        end
        exp_ev.push_back(e);
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("start_byte_ready", 64'(byte_ready), 64'd1);
        chk("start_clears_error", 64'(error), 64'd0);
    endtask

    // Sends bytes; rv randomises byte_valid; start is pulsed alongside byte index start_at.
    task automatic send(input byte_q_t b, input bit rv, input int start_at);
        int i = 0;
        int cyc = 0;
        bit pulsed = 1'b0;
        bit acc;
        while (i < b.size() && cyc < 20000) begin
            @(negedge clk);
            byte_data  = b[i];
            byte_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
            start      = !pulsed && (i == start_at);
            if (start) pulsed = 1'b1;
            #1 acc = byte_valid && byte_ready;
            @(posedge clk);
            if (acc) i++;
            cyc++;
        end
        #1;
        byte_valid = 1'b0;
        start      = 1'b0;
        if (i < b.size()) fail_now($sformatf("send_timeout sent=%0d of %0d", i, b.size()));
    endtask

    task automatic wait_events();
        int c = 0;
        while ((exp_ev.size() != 0 || exp_wr.size() != 0) && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (exp_ev.size() != 0 || exp_wr.size() != 0) begin
            fail_now($sformatf("event_timeout ev=%0d wr=%0d", exp_ev.size(), exp_wr.size()));
            exp_ev.delete();
            exp_wr.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_load(input word_q_t words, input int n, input bit corrupt,
                            input bit rv, input int start_at);
        byte_q_t b;
        b = build_stream(words, n, corrupt);
        push_expect(words, n, corrupt);
        pulse_start();
        send(b, rv, start_at);
        wait_events();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
        chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    function automatic word_q_t rand_words(input int n);
        word_q_t q;
        for (int k = 0; k < n; k++) q.push_back($urandom());
        return q;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        word_q_t wq;
        byte_q_t b;
        byte_q_t part;
        wr_t     w;

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset_n = 1'b1;
        @(negedge clk);

        // Single word, continuous valid: 01 00 93 00 C0 2B.
        wq = {};
        wq.push_back(32'h2BC00093);
        run_load(wq, 1, 1'b0, 1'b0, -1);

        // Three words with random valid.
        wq = {};
        wq.push_back(32'h11223344);
        wq.push_back(32'hAABBCCDD);
        wq.push_back(32'h00000013);
        run_load(wq, 3, 1'b0, 1'b1, -1);

        // Illegal lengths: 0 and DEPTH+1.
        wq = {};
        run_load(wq, 0, 1'b0, 1'b0, -1);
        chk("hold_after_len0_error", 64'(cpu_hold), 64'd1);
        run_load(wq, 1025, 1'b0, 1'b1, -1);
        chk("error_sticky", 64'(error), 64'd1);
        chk("hold_after_len1025_error", 64'(cpu_hold), 64'd1);

        // Reset after word 1 of 4 is written.
        wq = rand_words(4);
        b  = build_stream(wq, 4, 1'b0);
        for (int k = 0; k < 2; k++) begin
            w.addr = k;
            w.data = wq[k];
            exp_wr.push_back(w);
        end
        pulse_start();
        part = b[0:9];
        send(part, 1'b0, -1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("midload_reset");
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        chk("midload_writes_seen", 64'(exp_wr.size()), 64'd0);
        repeat (4) @(negedge clk);

        // Fresh load after the abort.
        run_load(rand_words(2), 2, 1'b0, 1'b1, -1);

        // start pulsed mid-payload must be ignored.
        run_load(rand_words(3), 3, 1'b0, 1'b1, 7);
        run_load(rand_words(2), 2, 1'b0, 1'b0, 4);

        // Random loads.
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 6);
            run_load(rand_words(n), n, 1'b0, 1'b1,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 4 * n)) : -1);
        end

        // Largest legal image.
        run_load(rand_words(DEPTH), DEPTH, 1'b0, 1'b0, -1);

`ifdef LOADER_CHECKSUM_EN
        // Payload 13 00 00 00: checksum 13 passes, 12 faults with the word written.
        wq = {};
        wq.push_back(32'h00000013);
        run_load(wq, 1, 1'b0, 1'b0, -1);
        run_load(wq, 1, 1'b1, 1'b0, -1);
        chk("csum_error_flag", 64'(error), 64'd1);
        chk("csum_error_hold", 64'(cpu_hold), 64'd1);
        run_load(rand_words(3), 3, 1'b1, 1'b1, -1);
        run_load(rand_words(3), 3, 1'b0, 1'b1, -1);
`endif

        chk("final_idle_ready", 64'(byte_ready), 64'd0);
        chk("final_exp_events_empty", 64'(exp_ev.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule
